// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fixed-latency reads, queues
// the returned words with their PCs and hands them on over valid/ready.
module fetch_prefetch_queue #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       MEM_LAT  = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       PC_STEP  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    mem_en,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_inst,
   output logic [ADDR_W-1:0]       out_pc,
   input  logic                    redirect_en,
   input  logic [ADDR_W-1:0]       redirect_addr,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned CW   = LW + 3;
   localparam int unsigned LAST = MEM_LAT - 1;

   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic               epoch_q, epoch_d;
   logic [MEM_LAT-1:0] pipe_vld_q, pipe_ep_q;
   logic [ADDR_W-1:0]  pipe_pc_q [MEM_LAT];
   logic [DATA_W-1:0]  fifo_inst_q [DEPTH];
   logic [ADDR_W-1:0]  fifo_pc_q [DEPTH];
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic [CW-1:0]      inflight, occupancy;
   logic               issue, push, pop, not_empty;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
         inflight = inflight + CW'(pipe_vld_q[i]);
      end
   end

   assign not_empty = (level_q != '0);
   assign out_valid = not_empty && !redirect_en;
   assign pop       = out_valid && out_ready;
   // A same-cycle pop returns its slot to the credit pool immediately.
   assign occupancy = CW'(level_q) + inflight - CW'(pop);
   assign issue     = !rst && !redirect_en && (occupancy < CW'(DEPTH));
   assign push      = pipe_vld_q[LAST] && (pipe_ep_q[LAST] == epoch_q) && !redirect_en;

   assign mem_en   = issue;
   assign mem_addr = fetch_pc_q;
   assign level    = level_q;
   assign out_inst = not_empty ? fifo_inst_q[rd_ptr_q] : '0;
   assign out_pc   = not_empty ? fifo_pc_q[rd_ptr_q] : '0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      epoch_d    = epoch_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      level_d    = level_q;
      if (redirect_en) begin
         fetch_pc_d = redirect_addr;
         epoch_d    = ~epoch_q;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         level_d    = '0;
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
         if (push)  wr_ptr_d   = wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_d   = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         epoch_q    <= 1'b0;
         pipe_vld_q <= '0;
         pipe_ep_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         epoch_q       <= epoch_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         level_q       <= level_d;
         pipe_vld_q[0] <= issue;
         pipe_ep_q[0]  <= epoch_q;
         for (int unsigned i = 1; i < MEM_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_ep_q[i]  <= pipe_ep_q[i-1];
         end
      end
   end

   // Data-path storage needs no reset: validity is carried by the flags above.
   always_ff @(posedge clk) begin
      pipe_pc_q[0] <= fetch_pc_q;
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
         pipe_pc_q[i] <= pipe_pc_q[i-1];
      end
      if (push) begin
         fifo_inst_q[wr_ptr_q] <= mem_data;
         fifo_pc_q[wr_ptr_q]   <= pipe_pc_q[LAST];
      end
   end

   assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && (level_q == LW'(DEPTH))));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised and directed checks of fetch_prefetch_queue against a
// stream-level reference model (expected PC sequence plus FIFO queue).
module tb_fetch_prefetch_queue;

   localparam int          DEPTH    = 4;
   localparam int          LAT      = 2;
   localparam int          STEP     = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk, rst, mem_en, out_valid, out_ready, redirect_en;
   logic [31:0] mem_addr, mem_data, out_inst, out_pc, redirect_addr;
   logic [2:0]  level;

   fetch_prefetch_queue #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .DEPTH    (DEPTH),
      .MEM_LAT  (LAT),
      .RESET_PC (RESET_PC),
      .PC_STEP  (STEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_en        (mem_en),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .level         (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int ret; logic [31:0] pc; int sid; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   int          n_tests, n_fail, cyc, sid_cur, exp_level;
   req_t        pend[$];
   ent_t        fifo_m[$];
   logic [31:0] nxt_pc, exp_addr, exp_pc, exp_inst;
   logic        exp_mem_en, exp_ov, exp_pop;
   logic        act_v [8];
   logic [31:0] act_a [8];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic model_eval();
      if (rst) begin
         exp_mem_en = 1'b0; exp_addr = RESET_PC; exp_ov = 1'b0;
         exp_pc = '0; exp_inst = '0; exp_level = 0; exp_pop = 1'b0;
      end else begin
         exp_level  = fifo_m.size();
         exp_ov     = (exp_level != 0) && !redirect_en;
         exp_pc     = (exp_level != 0) ? fifo_m[0].pc : 32'h0;
         exp_inst   = (exp_level != 0) ? fifo_m[0].inst : 32'h0;
         exp_pop    = exp_ov && out_ready;
         exp_mem_en = !redirect_en && ((exp_level + pend.size() - int'(exp_pop)) < DEPTH);
         exp_addr   = nxt_pc;
      end
   endtask

   task automatic model_update();
      req_t r;
      ent_t e;
      if (rst) begin
         pend.delete(); fifo_m.delete(); nxt_pc = RESET_PC; sid_cur++;
      end else begin
         if (exp_pop) void'(fifo_m.pop_front());
         if (pend.size() != 0 && pend[0].ret == cyc) begin
            r = pend.pop_front();
            if (r.sid == sid_cur && !redirect_en) begin
               e.pc = r.pc; e.inst = memf(r.pc); fifo_m.push_back(e);
            end
         end
         if (exp_mem_en) begin
            r.ret = cyc + LAT; r.pc = nxt_pc; r.sid = sid_cur;
            pend.push_back(r);
            nxt_pc = nxt_pc + STEP;
         end
         if (redirect_en) begin
            fifo_m.delete(); sid_cur++; nxt_pc = redirect_addr;
         end
      end
   endtask

   task automatic drive(input logic r, input logic re, input logic [31:0] ra, input logic rdy);
      int idx;
      rst = r; redirect_en = re; redirect_addr = ra; out_ready = rdy;
      idx = (cyc - LAT) & 7;
      if (cyc >= LAT && act_v[idx]) mem_data = memf(act_a[idx]);
      else mem_data = $urandom;
      @(negedge clk);
      model_eval();
      act_v[cyc & 7] = mem_en;
      act_a[cyc & 7] = mem_addr;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b0);
         finish_cycle();
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'h0, 1'b1);
         n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", mem_en); end
         n_tests++; if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_mem_addr got %h want %h", mem_addr, RESET_PC); end
         n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
         n_tests++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h/%h want 0/0", out_inst, out_pc); end
         n_tests++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
         finish_cycle();
      end
   endtask

   task automatic test_sequential();
      logic [31:0] want;
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         want = 32'(4 * k);
         n_tests++; if (mem_en !== 1'b1 || mem_addr !== want) begin n_fail++; $display("FAIL seq_issue k=%0d got %b/%h want 1/%h", k, mem_en, mem_addr, want); end
         n_tests++; if (out_valid !== (k >= LAT + 1)) begin n_fail++; $display("FAIL seq_valid k=%0d got %b want %b", k, out_valid, k >= LAT + 1); end
         if (k >= LAT + 1) begin
            want = 32'(4 * (k - LAT - 1));
            n_tests++; if (out_pc !== want || out_inst !== memf(want)) begin n_fail++; $display("FAIL seq_out k=%0d got %h/%h want %h/%h", k, out_pc, out_inst, want, memf(want)); end
         end
         n_tests++; if (level !== 3'(exp_level)) begin n_fail++; $display("FAIL seq_level k=%0d got %0d want %0d", k, level, exp_level); end
         finish_cycle();
      end
   endtask

   task automatic test_stall();
      logic [31:0] want;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b0);
         n_tests++; if (mem_en !== (k < 4)) begin n_fail++; $display("FAIL stall_mem_en k=%0d got %b want %b", k, mem_en, k < 4); end
         n_tests++; if (level !== 3'(exp_level)) begin n_fail++; $display("FAIL stall_level k=%0d got %0d want %0d", k, level, exp_level); end
         if (k == 9) begin
            n_tests++; if (level !== 3'd4) begin n_fail++; $display("FAIL stall_full got %0d want 4", level); end
         end
         finish_cycle();
      end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         want = 32'(4 * k);
         n_tests++; if (out_valid !== 1'b1 || out_pc !== want || out_inst !== memf(want)) begin n_fail++; $display("FAIL stall_drain k=%0d got %b/%h want 1/%h", k, out_valid, out_pc, want); end
         want = 32'(16 + 4 * k);
         n_tests++; if (mem_en !== 1'b1 || mem_addr !== want) begin n_fail++; $display("FAIL stall_resume k=%0d got %b/%h want 1/%h", k, mem_en, mem_addr, want); end
         finish_cycle();
      end
   endtask

   task automatic test_redirect();
      for (int k = 0; k < 4; k++) begin drive(1'b0, 1'b0, 32'h0, 1'b1); finish_cycle(); end
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, k == 0, 32'h100, 1'b1);
         if (k == 0) begin
            n_tests++; if (mem_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_cycle got %b/%b want 0/0", mem_en, out_valid); end
         end
         if (k == 1) begin
            n_tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_issue got %b/%h want 1/00000100", mem_en, mem_addr); end
         end
         if (k >= 1 && k <= 3) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale k=%0d got valid %b pc %h want 0", k, out_valid, out_pc); end
         end
         if (k >= 4) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h100 + 4 * (k - 4))) begin n_fail++; $display("FAIL redir_out k=%0d got %b/%h want 1/%h", k, out_valid, out_pc, 32'h100 + 4 * (k - 4)); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_double_redirect();
      logic [31:0] ra;
      for (int k = 0; k < 7; k++) begin
         ra = (k == 0) ? 32'h200 : 32'h300;
         drive(1'b0, k < 2, ra, 1'b1);
         if (k < 2) begin
            n_tests++; if (mem_en !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_cycle k=%0d got %b/%b want 0/0", k, mem_en, out_valid); end
         end
         if (k == 2) begin
            n_tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL dbl_issue got %b/%h want 1/00000300", mem_en, mem_addr); end
         end
         if (k >= 2 && k <= 4) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dbl_stale k=%0d got valid %b pc %h want 0", k, out_valid, out_pc); end
         end
         if (k >= 5) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== 32'(32'h300 + 4 * (k - 5))) begin n_fail++; $display("FAIL dbl_out k=%0d got %b/%h want 1/%h", k, out_valid, out_pc, 32'h300 + 4 * (k - 5)); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, k == 0, 32'hFFFF_FFFC, 1'b1);
         if (k == 1 || k == 2) begin
            n_tests++; if (mem_en !== 1'b1 || mem_addr !== ((k == 1) ? 32'hFFFF_FFFC : 32'h0)) begin n_fail++; $display("FAIL wrap_issue k=%0d got %b/%h", k, mem_en, mem_addr); end
         end
         if (k == 4 || k == 5) begin
            n_tests++; if (out_valid !== 1'b1 || out_pc !== ((k == 4) ? 32'hFFFF_FFFC : 32'h0) || out_inst !== memf(out_pc)) begin n_fail++; $display("FAIL wrap_out k=%0d got %b/%h/%h", k, out_valid, out_pc, out_inst); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 5; k++) begin drive(1'b0, 1'b0, 32'h0, 1'b0); finish_cycle(); end
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      n_tests++; if (level !== 3'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got level %0d valid %b want 3/1", level, out_valid); end
      rst = 1'b1;
      #1;
      n_tests++; if (mem_en !== 1'b0 || mem_addr !== RESET_PC) begin n_fail++; $display("FAIL rstmid_mem got %b/%h want 0/%h", mem_en, mem_addr, RESET_PC); end
      n_tests++; if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0 || level !== 3'd0) begin n_fail++; $display("FAIL rstmid_out got %b/%h/%h/%0d want all 0", out_valid, out_inst, out_pc, level); end
      finish_cycle();
      drive(1'b1, 1'b0, 32'h0, 1'b1);
      finish_cycle();
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, 1'b0, 32'h0, 1'b1);
         n_tests++; if (mem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL rstmid_issue k=%0d got %h want %h", k, mem_addr, 32'(4 * k)); end
         n_tests++; if (out_valid !== (k >= LAT + 1)) begin n_fail++; $display("FAIL rstmid_valid k=%0d got %b pc %h", k, out_valid, out_pc); end
         if (k >= LAT + 1) begin
            n_tests++; if (out_pc !== 32'(4 * (k - LAT - 1))) begin n_fail++; $display("FAIL rstmid_out k=%0d got %h want %h", k, out_pc, 32'(4 * (k - LAT - 1))); end
         end
         finish_cycle();
      end
   endtask

   task automatic test_random();
      logic r, re, rdy;
      logic [31:0] ra;
      for (int k = 0; k < 600; k++) begin
         r   = ($urandom_range(0, 99) < 2);
         re  = !r && ($urandom_range(0, 99) < 6);
         ra  = $urandom & 32'hFFFF_FFFC;
         rdy = ($urandom_range(0, 99) < 70);
         drive(r, re, ra, rdy);
         n_tests++; if (mem_en !== exp_mem_en) begin n_fail++; $display("FAIL rnd_mem_en cyc=%0d got %b want %b", cyc, mem_en, exp_mem_en); end
         n_tests++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_mem_addr cyc=%0d got %h want %h", cyc, mem_addr, exp_addr); end
         n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid cyc=%0d got %b want %b", cyc, out_valid, exp_ov); end
         n_tests++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_out_pc cyc=%0d got %h want %h", cyc, out_pc, exp_pc); end
         n_tests++; if (out_inst !== exp_inst) begin n_fail++; $display("FAIL rnd_out_inst cyc=%0d got %h want %h", cyc, out_inst, exp_inst); end
         n_tests++; if (level !== 3'(exp_level)) begin n_fail++; $display("FAIL rnd_level cyc=%0d got %0d want %0d", cyc, level, exp_level); end
         finish_cycle();
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; cyc = 0; sid_cur = 0; nxt_pc = RESET_PC;
      for (int i = 0; i < 8; i++) begin act_v[i] = 1'b0; act_a[i] = '0; end
      rst = 1'b1; redirect_en = 1'b0; redirect_addr = '0; out_ready = 1'b0; mem_data = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_double_redirect();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
